arb_out_buffer: RTL

Elastic 32-bit word buffer between the round-robin arbiter output and the SRAM FIFO input in the MIO readout path. It absorbs arbiter bursts and presents a show-ahead, empty-flagged word stream to the SRAM FIFO. It also inserts periodic sequence-numbered marker words for stream integrity checks, and tracks accepted, lost and high-water statistics.

---
 rtl/arb_out_buffer_if.sv | 29 ++
 rtl/arb_out_buffer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/arb_out_buffer_if.sv
// Handshake and word bus between the arbiter / SRAM FIFO side and the
// elastic output buffer. The buffer takes the slave view; whoever drives
// the arbiter words and the pop strobe takes the master view.
interface arb_out_buffer_if;
    logic        WRITE_IN;
    logic [31:0] DATA_IN;
    logic        READY_OUT;
    logic        FIFO_READ;
    logic        FIFO_EMPTY;
    logic [31:0] FIFO_DATA;

    modport master (
        output WRITE_IN,
        output DATA_IN,
        output FIFO_READ,
        input  READY_OUT,
        input  FIFO_EMPTY,
        input  FIFO_DATA
    );

    modport slave (
        input  WRITE_IN,
        input  DATA_IN,
        input  FIFO_READ,
        output READY_OUT,
        output FIFO_EMPTY,
        output FIFO_DATA
    );
endinterface

// File: rtl/arb_out_buffer.sv
// Elastic word buffer between the round-robin arbiter and the SRAM FIFO.
// Circular RAM with extra-bit pointers, registered show-ahead head word,
// periodic sequence-numbered marker insertion and traffic statistics.
module arb_out_buffer #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter logic [3:0]  MARKER_ID  = 4'hF
) (
    input  logic                BUS_CLK,
    input  logic                BUS_RST,
    arb_out_buffer_if.slave     bus,
    input  logic                MARKER_EN,
    input  logic [15:0]         MARKER_PERIOD,
    output logic [31:0]         WORD_CNT,
    output logic [15:0]         LOST_CNT,
    output logic [DEPTH_LOG2:0] MAX_LEVEL
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] PTR_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0] PTR_ZERO   = {(DEPTH_LOG2 + 1){1'b0}};

    typedef enum logic [0:0] {
        S_RUN = 1'b0,
        S_INS = 1'b1
    } state_t;

    // Marker word layout: ID nibble, zero pad, 16-bit sequence number.
    function automatic logic [31:0] marker_word(input logic [15:0] seq_val);
        marker_word = {MARKER_ID, 12'h000, seq_val};
    endfunction

    // Storage and registered state
    logic [31:0]         mem_r [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_r;
    logic [DEPTH_LOG2:0] rd_ptr_r;
    logic                empty_r;
    logic [31:0]         data_r;
    logic                ready_r;
    state_t              state_r;
    logic [15:0]         cnt_r;
    logic [15:0]         seq_r;
    logic [31:0]         word_cnt_r;
    logic [15:0]         lost_cnt_r;
    logic [DEPTH_LOG2:0] max_level_r;

    // Combinational datapath terms
    logic [DEPTH_LOG2:0] level_s;
    logic                not_full_s;
    logic                ready_s;
    logic                marker_act_s;
    logic                period_hit_s;
    logic                data_wr_s;
    logic                drop_s;
    logic                mark_wr_s;
    logic                any_wr_s;
    logic                pop_s;
    logic [31:0]         wr_data_s;
    logic [DEPTH_LOG2:0] wr_ptr_nxt_s;
    logic [DEPTH_LOG2:0] rd_ptr_nxt_s;
    logic [DEPTH_LOG2:0] level_nxt_s;
    logic [31:0]         head_s;

    // Write/pop qualification, next pointers and the next show-ahead head word.
    always_comb begin
        level_s      = wr_ptr_r - rd_ptr_r;
        not_full_s   = (level_s != FULL_LEVEL);
        // ready_r already encodes "not full and not inserting"; reset gates it.
        ready_s      = ~BUS_RST & ready_r;
        marker_act_s = MARKER_EN & (MARKER_PERIOD != 16'd0);
        period_hit_s = (cnt_r == (MARKER_PERIOD - 16'd1));
        data_wr_s    = bus.WRITE_IN & ready_s;
        drop_s       = bus.WRITE_IN & ~ready_s;
        // Data writes are impossible in S_INS, so the two write sources never collide.
        mark_wr_s    = (state_r == S_INS) & marker_act_s & not_full_s;
        any_wr_s     = data_wr_s | mark_wr_s;
        // A word written into an empty buffer is not poppable until it is registered.
        pop_s        = bus.FIFO_READ & ~empty_r;
        wr_data_s    = mark_wr_s ? marker_word(seq_r) : bus.DATA_IN;
        wr_ptr_nxt_s = any_wr_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
        rd_ptr_nxt_s = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
        level_nxt_s  = wr_ptr_nxt_s - rd_ptr_nxt_s;
        // Bypass the RAM when the word being written becomes the new head.
        if (any_wr_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_s = wr_data_s;
        end else begin
            head_s = mem_r[rd_ptr_nxt_s[DEPTH_LOG2-1:0]];
        end
    end

    // Buffer RAM write port; contents are don't-care until written.
    always_ff @(posedge BUS_CLK) begin
        if (any_wr_s && !BUS_RST) begin
            mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= wr_data_s;
        end
    end

    // Pointers, registered show-ahead head/empty flag and statistics counters.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            empty_r     <= 1'b1;
            data_r      <= 32'h0000_0000;
            word_cnt_r  <= 32'd0;
            lost_cnt_r  <= 16'd0;
            max_level_r <= PTR_ZERO;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            empty_r  <= (level_nxt_s == PTR_ZERO);
            data_r   <= (level_nxt_s == PTR_ZERO) ? 32'h0000_0000 : head_s;
            if (data_wr_s) begin
                word_cnt_r <= word_cnt_r + 32'd1;
            end
            if (drop_s && (lost_cnt_r != 16'hFFFF)) begin
                lost_cnt_r <= lost_cnt_r + 16'd1;
            end
            if (level_s > max_level_r) begin
                max_level_r <= level_s;
            end
        end
    end

    // Marker FSM: period counter, pending-marker state, sequence number and ready flag.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state_r <= S_RUN;
            cnt_r   <= 16'd0;
            seq_r   <= 16'd0;
            ready_r <= 1'b1;
        end else if (!marker_act_s) begin
            // Disabled: clear the cadence and drop any pending marker, keep seq.
            state_r <= S_RUN;
            cnt_r   <= 16'd0;
            ready_r <= (level_nxt_s != FULL_LEVEL);
        end else begin
            cnt_r <= period_hit_s ? 16'd0 : (cnt_r + 16'd1);
            case (state_r)
                S_RUN: begin
                    if (period_hit_s) begin
                        state_r <= S_INS;
                        ready_r <= 1'b0;
                    end else begin
                        state_r <= S_RUN;
                        ready_r <= (level_nxt_s != FULL_LEVEL);
                    end
                end
                S_INS: begin
                    // Expiries seen here are discarded: only one marker may pend.
                    if (not_full_s) begin
                        state_r <= S_RUN;
                        seq_r   <= seq_r + 16'd1;
                        ready_r <= (level_nxt_s != FULL_LEVEL);
                    end else begin
                        state_r <= S_INS;
                        ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= S_RUN;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.READY_OUT  = ready_s;
    assign bus.FIFO_EMPTY = empty_r;
    assign bus.FIFO_DATA  = data_r;
    assign WORD_CNT       = word_cnt_r;
    assign LOST_CNT       = lost_cnt_r;
    assign MAX_LEVEL      = max_level_r;

endmodule
